// File: rtl/multi_vend_ctrl.sv
// multi_vend_ctrl -- multi-product vending machine controller.
//
// Accepts coins into a credit register, vends a selected product when credit
// and stock allow, and returns the remaining credit as change. Each product
// has a 4-bit stock counter that refill reloads.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   coin_valid/val    coin strobe; value 00=5, 01=10, 10=20, 11=50
//   sel_valid/idx     product-select strobe and item index
//   cancel            return all credit as change
//   refill            reload every stock counter to STOCK_INIT
//   vend_valid/idx    one-cycle dispense pulse and item (idx 0 when idle)
//   change_valid/amt  one-cycle change pulse and amount (amt 0 when idle)
//   credit            current credit
//   coin_reject       one-cycle pulse for a refused or dropped coin
//   sel_reject        one-cycle pulse for a refused selection
//   sold_out          bit i set when item i has no stock
//   busy              high while dispensing or returning change
module multi_vend_ctrl #(
  parameter int unsigned NUM_ITEMS  = 4,
  parameter int unsigned CREDIT_W   = 8,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {8'd50, 8'd40, 8'd25, 8'd15},
  parameter int unsigned MAX_CREDIT = 100,
  parameter int unsigned STOCK_INIT = 3,
  localparam int unsigned IDX_W     = $clog2(NUM_ITEMS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 coin_valid,
  input  logic [1:0]           coin_val,
  input  logic                 sel_valid,
  input  logic [IDX_W-1:0]     sel_idx,
  input  logic                 cancel,
  input  logic                 refill,
  output logic                 vend_valid,
  output logic [IDX_W-1:0]     vend_idx,
  output logic                 change_valid,
  output logic [CREDIT_W-1:0]  change_amt,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 coin_reject,
  output logic                 sel_reject,
  output logic [NUM_ITEMS-1:0] sold_out,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

  localparam logic [3:0] STOCK_RST = 4'(STOCK_INIT);
  localparam logic [NUM_ITEMS-1:0] SOLD_RST = (STOCK_INIT == 0) ? '1 : '0;

  state_t                state;
  logic [3:0]            stock [NUM_ITEMS];

  logic [CREDIT_W-1:0]   coin_amt;
  logic [CREDIT_W:0]     coin_sum;
  logic                  coin_fits;
  logic [NUM_ITEMS-1:0]  sel_hit;
  logic [CREDIT_W-1:0]   sel_price;
  logic                  sel_in_stock;
  logic                  sel_ok;

  always_comb begin
    case (coin_val)
      2'b00:   coin_amt = CREDIT_W'(5);
      2'b01:   coin_amt = CREDIT_W'(10);
      2'b10:   coin_amt = CREDIT_W'(20);
      default: coin_amt = CREDIT_W'(50);
    endcase
    // One extra bit so credit + coin cannot wrap before the limit check.
    coin_sum  = {1'b0, credit} + {1'b0, coin_amt};
    coin_fits = (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
  end

  // Decode the selection by matching against each item rather than indexing,
  // so an index beyond NUM_ITEMS simply matches nothing.
  always_comb begin
    sel_hit      = '0;
    sel_price    = '0;
    sel_in_stock = 1'b0;
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_hit[i]   = 1'b1;
        sel_price    = PRICES[i*CREDIT_W +: CREDIT_W];
        sel_in_stock = (stock[i] != 4'd0);
      end
    end
    sel_ok = (|sel_hit) && (credit >= sel_price) && sel_in_stock;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      credit       <= '0;
      vend_valid   <= 1'b0;
      vend_idx     <= '0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      coin_reject  <= 1'b0;
      sel_reject   <= 1'b0;
      busy         <= 1'b0;
      sold_out     <= SOLD_RST;
      for (int unsigned i = 0; i < NUM_ITEMS; i++) stock[i] <= STOCK_RST;
    end else begin
      vend_valid   <= 1'b0;
      vend_idx     <= '0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      coin_reject  <= 1'b0;
      sel_reject   <= 1'b0;
      busy         <= 1'b0;

      case (state)
        IDLE, CREDIT: begin
          if (state == CREDIT && cancel) begin
            state        <= CHANGE;
            change_valid <= 1'b1;
            change_amt   <= credit;
            busy         <= 1'b1;
            coin_reject  <= coin_valid;
          end else if (sel_valid) begin
            coin_reject <= coin_valid;
            if (state == CREDIT && sel_ok) begin
              state      <= VEND;
              credit     <= credit - sel_price;
              vend_valid <= 1'b1;
              vend_idx   <= sel_idx;
              busy       <= 1'b1;
              for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
                if (sel_hit[i]) begin
                  stock[i]    <= stock[i] - 4'd1;
                  sold_out[i] <= (stock[i] == 4'd1);
                end
              end
            end else begin
              sel_reject <= 1'b1;
            end
          end else if (coin_valid) begin
            if (coin_fits) begin
              credit <= coin_sum[CREDIT_W-1:0];
              state  <= CREDIT;
            end else begin
              coin_reject <= 1'b1;
            end
          end
        end

        VEND: begin
          coin_reject <= coin_valid;
          sel_reject  <= sel_valid;
          if (credit != '0) begin
            state        <= CHANGE;
            change_valid <= 1'b1;
            change_amt   <= credit;
            busy         <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end

        CHANGE: begin
          coin_reject <= coin_valid;
          sel_reject  <= sel_valid;
          credit      <= '0;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase

      // Placed last so a refill overrides a same-cycle stock decrement.
      if (refill) begin
        sold_out <= SOLD_RST;
        for (int unsigned i = 0; i < NUM_ITEMS; i++) stock[i] <= STOCK_RST;
      end
    end
  end

endmodule

// File: tb/tb_multi_vend_ctrl.sv
// tb_multi_vend_ctrl -- directed scenarios followed by random stimulus, all
// checked cycle by cycle against a credit/stock reference model.
module tb_multi_vend_ctrl;

  localparam int N = 4;
  localparam int PRICE [N] = '{15, 25, 40, 50};
  localparam int COIN  [4] = '{5, 10, 20, 50};
  localparam int MAXC  = 100;
  localparam int SINIT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_val = '0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_idx = '0;
  logic       cancel = 1'b0;
  logic       refill = 1'b0;
  logic       vend_valid;
  logic [1:0] vend_idx;
  logic       change_valid;
  logic [7:0] change_amt;
  logic [7:0] credit;
  logic       coin_reject;
  logic       sel_reject;
  logic [3:0] sold_out;
  logic       busy;

  multi_vend_ctrl #(
    .NUM_ITEMS (4),
    .CREDIT_W  (8),
    .PRICES    ({8'd50, 8'd40, 8'd25, 8'd15}),
    .MAX_CREDIT(100),
    .STOCK_INIT(3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .coin_valid   (coin_valid),
    .coin_val     (coin_val),
    .sel_valid    (sel_valid),
    .sel_idx      (sel_idx),
    .cancel       (cancel),
    .refill       (refill),
    .vend_valid   (vend_valid),
    .vend_idx     (vend_idx),
    .change_valid (change_valid),
    .change_amt   (change_amt),
    .credit       (credit),
    .coin_reject  (coin_reject),
    .sel_reject   (sel_reject),
    .sold_out     (sold_out),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: money held, items left, and whether the machine is in
  // its dispense cycle or its refund cycle.
  int m_credit;
  int m_stock [N];
  bit m_dispensing;
  bit m_refunding;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit cv, input logic [1:0] cval,
                      input bit sv, input logic [1:0] sidx,
                      input bit cn, input bit rf);
    int e_vend, e_vidx, e_chg, e_amt, e_crej, e_srej, e_sold;
    rst = r; coin_valid = cv; coin_val = cval; sel_valid = sv;
    sel_idx = sidx; cancel = cn; refill = rf;
    @(posedge clk);
    #1;
    e_vend = 0; e_vidx = 0; e_chg = 0; e_amt = 0; e_crej = 0; e_srej = 0;
    if (r) begin
      m_credit = 0; m_dispensing = 0; m_refunding = 0;
      for (int i = 0; i < N; i++) m_stock[i] = SINIT;
    end else begin
      if (m_dispensing) begin
        e_crej = cv; e_srej = sv;
        m_dispensing = 0;
        if (m_credit > 0) begin
          m_refunding = 1; e_chg = 1; e_amt = m_credit;
        end
      end else if (m_refunding) begin
        e_crej = cv; e_srej = sv;
        m_credit = 0; m_refunding = 0;
      end else begin
        bit has_credit = (m_credit > 0);
        int idx = int'(sidx);
        if (has_credit && cn) begin
          m_refunding = 1; e_chg = 1; e_amt = m_credit; e_crej = cv;
        end else if (sv) begin
          e_crej = cv;
          if (has_credit && idx < N && m_credit >= PRICE[idx] && m_stock[idx] > 0) begin
            m_credit -= PRICE[idx];
            m_stock[idx]--;
            m_dispensing = 1; e_vend = 1; e_vidx = idx;
          end else begin
            e_srej = 1;
          end
        end else if (cv) begin
          if (m_credit + COIN[cval] <= MAXC) m_credit += COIN[cval];
          else e_crej = 1;
        end
      end
      if (rf) for (int i = 0; i < N; i++) m_stock[i] = SINIT;
    end
    e_sold = 0;
    for (int i = 0; i < N; i++) if (m_stock[i] == 0) e_sold |= (1 << i);

    check("credit",       32'(credit),       32'(m_credit));
    check("vend_valid",   32'(vend_valid),   32'(e_vend));
    check("vend_idx",     32'(vend_idx),     32'(e_vidx));
    check("change_valid", 32'(change_valid), 32'(e_chg));
    check("change_amt",   32'(change_amt),   32'(e_amt));
    check("coin_reject",  32'(coin_reject),  32'(e_crej));
    check("sel_reject",   32'(sel_reject),   32'(e_srej));
    check("sold_out",     32'(sold_out),     32'(e_sold));
    check("busy",         32'(busy),         32'(m_dispensing | m_refunding));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 2'b00, 0, 2'd0, 0, 0);
  endtask

  task automatic coin(input logic [1:0] v);
    step(0, 1, v, 0, 2'd0, 0, 0);
  endtask

  task automatic sel(input logic [1:0] i);
    step(0, 0, 2'b00, 1, i, 0, 0);
  endtask

  initial begin
    step(1, 0, 2'b00, 0, 2'd0, 0, 0);
    step(1, 1, 2'b11, 1, 2'd2, 1, 1);
    idle(1);

    // 10 + 10, buy item 0 (15): vend then change of 5.
    coin(2'b01); coin(2'b01); sel(2'd0);
    check("s1_vend_idx", 32'(vend_idx), 32'd0);
    idle(1);
    check("s1_change_amt", 32'(change_amt), 32'd5);
    idle(1);
    check("s1_credit", 32'(credit), 32'd0);

    // Fill to the limit, extra coin refused, cancel returns 100.
    coin(2'b11); coin(2'b11); coin(2'b00);
    check("s2_coin_reject", 32'(coin_reject), 32'd1);
    step(0, 0, 2'b00, 0, 2'd0, 1, 0);
    check("s2_change_amt", 32'(change_amt), 32'd100);
    idle(1);

    // 20 is not enough for item 1.
    coin(2'b10); sel(2'd1);
    check("s3_sel_reject", 32'(sel_reject), 32'd1);
    step(0, 0, 2'b00, 0, 2'd0, 1, 0); idle(1);

    // Empty item 3, then a fourth select is refused, refill restores it.
    for (int k = 0; k < 3; k++) begin
      coin(2'b11); sel(2'd3); idle(1);
    end
    check("s4_sold_out3", 32'(sold_out[3]), 32'd1);
    coin(2'b11); sel(2'd3);
    check("s4_sel_reject", 32'(sel_reject), 32'd1);
    step(0, 0, 2'b00, 0, 2'd0, 0, 1);
    check("s4_refill", 32'(sold_out[3]), 32'd0);
    step(0, 0, 2'b00, 0, 2'd0, 1, 0); idle(1);

    // Cancel beats a same-cycle selection.
    coin(2'b10); coin(2'b01);
    step(0, 0, 2'b00, 1, 2'd0, 1, 0);
    check("s5_no_vend", 32'(vend_valid), 32'd0);
    check("s5_change_amt", 32'(change_amt), 32'd30);
    idle(1);

    // Reset in the dispense cycle discards the pending change.
    coin(2'b11); sel(2'd0);
    step(1, 0, 2'b00, 0, 2'd0, 0, 0);
    check("s6_no_change", 32'(change_valid), 32'd0);
    check("s6_credit", 32'(credit), 32'd0);
    idle(2);

    // Refill coincident with a vend of a last item.
    for (int k = 0; k < 2; k++) begin
      coin(2'b11); sel(2'd2); idle(2);
    end
    coin(2'b11);
    step(0, 0, 2'b00, 1, 2'd2, 0, 1);
    idle(3);

    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 39) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
